// File: rtl/alu_4_pkg.sv
// Shared definitions for the alu_4 datapath and its requester arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_4_pkg;

    localparam int ALU_IN_W  = 4;
    localparam int ALU_OUT_W = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One latched ALU operation: operands plus the opcode, carried opaquely.
    typedef struct packed {
        logic [ALU_IN_W-1:0] a;
        logic [ALU_IN_W-1:0] b;
        logic [1:0]          opcode;
    } alu_op_t;

endpackage

// File: rtl/alu_4.sv
// 4-bit ALU: add, subtract, and, or; carry/borrow lands in result[4].
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; opcode selects the operation; result is 5 bits.
module alu_4
    import alu_4_pkg::*;
(
    input  logic [ALU_IN_W-1:0]  a,
    input  logic [ALU_IN_W-1:0]  b,
    input  logic [1:0]           opcode,
    output logic [ALU_OUT_W-1:0] result
);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD: result = {1'b0, a} + {1'b0, b};
            // Wraps modulo 32, so a < b leaves the borrow set in bit 4.
            OP_SUB: result = {1'b0, a} - {1'b0, b};
            OP_AND: result = {1'b0, a & b};
            OP_OR:  result = {1'b0, a | b};
        endcase
    end

endmodule

// File: rtl/alu_4_arbiter_rr_pick.sv
// Round-robin winner search over N_REQ request lines.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req request vector; last_grant previous winner; grant one-hot winner
//        (zero when no request); idx binary index of the winner.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Scan starts one past the previous winner, so the previous winner is
    // considered last.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/alu_4_arbiter.sv
// Shares one alu_4 among N_REQ requesters, round-robin, one op in flight.
// Latency: result valid two cycles after the accept cycle (3-cycle minimum occupancy).
// Backpressure: a held result stalls the whole arbiter; no request buffering.
// Ports: clk, rst (async, active high); req_valid/req_ready/req_a/req_b/req_opcode
//        per-requester request channel; rsp_valid/rsp_ready per-requester response
//        handshake; rsp_data shared registered result; busy high outside IDLE.
// Build option ALU_4_ARBITER_STATS_EN adds stats_clr and grant_count (8-bit
// saturating accept counters per requester).
module alu_4_arbiter
    import alu_4_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [ALU_IN_W*N_REQ-1:0] req_a,
    input  logic [ALU_IN_W*N_REQ-1:0] req_b,
    input  logic [2*N_REQ-1:0]        req_opcode,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [ALU_OUT_W-1:0]      rsp_data,
`ifdef ALU_4_ARBITER_STATS_EN
    input  logic                      stats_clr,
    output logic [8*N_REQ-1:0]        grant_count,
`endif
    output logic                      busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t                state;
    state_t                state_nxt;
    alu_op_t               op_q;
    alu_op_t               sel_op;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      last_grant_q;
    logic [IDX_W-1:0]      pick_idx;
    logic [N_REQ-1:0]      pick_oh;
    logic [ALU_OUT_W-1:0]  alu_result;
    logic                  accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_oh),
        .idx        (pick_idx)
    );

    alu_4 u_alu (
        .a      (op_q.a),
        .b      (op_q.b),
        .opcode (op_q.opcode),
        .result (alu_result)
    );

    assign accept = (state == ST_IDLE) && (|req_valid);

    // Operand mux for the current winner.
    always_comb begin
        sel_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_op.a      = req_a[i*ALU_IN_W +: ALU_IN_W];
                sel_op.b      = req_b[i*ALU_IN_W +: ALU_IN_W];
                sel_op.opcode = req_opcode[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|req_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready[grant_q]) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            ST_IDLE: req_ready = pick_oh;
            ST_RESP: rsp_valid[grant_q] = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // last_grant resets to the top index so requester 0 wins the first search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_REQ - 1);
            rsp_data     <= '0;
        end else begin
            if (accept) begin
                op_q    <= sel_op;
                grant_q <= pick_idx;
            end
            if (state == ST_EXEC) begin
                rsp_data <= alu_result;
            end
            // Rotation advances only once the result is handed off.
            if ((state == ST_RESP) && rsp_ready[grant_q]) begin
                last_grant_q <= grant_q;
            end
        end
    end

`ifdef ALU_4_ARBITER_STATS_EN
    // Clear wins over a same-cycle increment; counters stick at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count <= '0;
        end else if (stats_clr) begin
            grant_count <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pick_oh[i] && (grant_count[8*i +: 8] != 8'hff)) begin
                    grant_count[8*i +: 8] <= grant_count[8*i +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule
